qspi_read_prefetch: RTL and testbench
=====================================

Name: qspi_read_prefetch

Overview:
- Per-transaction read scheduler between the QSPI command FSM and the NOR Wishbone slave.
- After a READ or FAST_READ address phase it streams sequential NOR reads into a small FIFO ahead of the host.
- Each consumed data word is served from the FIFO, so continuous quad reads never wait on NOR access latency.
- It lives entirely in the clk_i domain and is cleared on every CE deassertion.

Parameters:
- ADDRBITS, 26, NOR word-address width.
- DATABITS, 16, NOR data word width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- NOR_CMD_READ, `NOR_CYCLE_READ, 6-bit NOR command placed in wb_adr_o[31:26].

Ports:
- clk_i  in  1  system clock.
- spi_reset  in  1  asynchronous, active-high reset; the combination of reset_i and synchronized CE-high.
- start_i  in  1  one-cycle pulse: read address phase complete.
- start_addr_i  in  ADDRBITS  first word address, sampled when start_i is high.
- pop_i  in  1  one-cycle word strobe: host consumed rd_data_o.
- rd_data_o  out  DATABITS  FIFO head word.
- rd_valid_o  out  1  FIFO not empty.
- busy_o  out  1  state != IDLE.
- underrun_o  out  1  sticky: pop_i arrived while the FIFO was empty.
- err_o  out  1  sticky: wb_err_i was received.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  constant 0.
- wb_adr_o  out  32  {NOR_CMD_READ, word address}.
- wb_dat_i  in  DATABITS  read data.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_stall_i  in  1  Wishbone pipelined stall.
- wb_err_i  in  1  Wishbone error.

Behaviour:
- Reset (async, any time): state=IDLE; FIFO pointers/count=0; fetch address=0.
- Reset output values: all outputs 0; rd_data_o=0.
- Reset mid-cycle drops wb_cyc_o/wb_stb_o immediately (Wishbone abort). Any later ack is ignored, since state is IDLE.
- FSM states: IDLE, ISSUE, WAIT, HALT.
- IDLE: on start_i, latch fetch_addr=start_addr_i and go to ISSUE. start_i in any other state is ignored.
- ISSUE: entered only when count < DEPTH; otherwise the FSM sits in a space-wait inside ISSUE with cyc/stb low.
  - With space: assert cyc=stb=1 and adr={NOR_CMD_READ, fetch_addr}.
  - When stb=1 and !wb_stall_i: next cycle stb=0, cyc stays 1, go to WAIT.
- WAIT:
  - On wb_ack_i: push wb_dat_i, cyc=0, fetch_addr+=1, return to ISSUE.
  - On wb_err_i: cyc=0, set err_o, go to HALT.
  - ack and err in the same cycle: err wins and no push.
- HALT: no further fetches. FIFO still drains on pop. Exit only via spi_reset.
- Outstanding accesses: exactly one. Space check is count < DEPTH at ISSUE entry; the in-flight word is counted by holding count+1 reserved, i.e. issue only if count+inflight < DEPTH.
- fetch_addr wraps modulo 2^ADDRBITS (all-ones -> 0). The upper six address bits are never disturbed.
- Latency, start to data: start_i at edge 0 -> cyc/stb high after edge 0. With no stall and ack k cycles after stb, rd_valid_o rises on the edge after the ack.
- FIFO:
  - Registered storage; rd_data_o is the head entry and is valid while rd_valid_o.
  - Push on ack, pop on pop_i && rd_valid_o. Push and pop in the same cycle leaves count unchanged.
  - Push when full cannot occur by construction. The bench asserts it never happens.
- Underrun: pop_i with count=0 sets underrun_o. Pointers are unchanged and rd_data_o holds its previous value.
- busy_o=1 in ISSUE/WAIT/HALT.

Decomposition:
- The NOR_CYCLE_* and SPI_COMMAND_* codes stay in the shared cmd_defs.v defines. No new package constants are needed beyond NOR_CMD_READ defaulting to `NOR_CYCLE_READ.
- One natural sub-module: sync_fifo (DEPTH x DATABITS, push/pop/count/empty/full, async reset). The top level holds the FSM, fetch address and Wishbone driver.

Test Plan:
- Prefill: start_i with addr 0x0000100, ack latency 3, no pops -> exactly 4 reads at 0x100..0x103, adr[31:26]=NOR_CMD_READ, then cyc stays low. rd_data_o equals the slave word for 0x100.
- Streaming: pop every 10 cycles for 12 words with data = address -> rd_data_o sequence is 0x100..0x10B. No underrun. One read is reissued after each pop.
- Wrap and stall: start at 0x3FFFFFE, stall held 2 cycles per request -> addresses 0x3FFFFFE, 0x3FFFFFF, 0x0000000, 0x0000001. stb drops only after stall is low.
- Underrun: start, then pop on the cycle after start_i, ack latency 8 -> underrun_o=1 and stays set. The first valid word is still address start.
- Error: wb_err_i on the 2nd read -> err_o=1, state HALT, no further cyc. The word already fetched is still poppable.
- Abort: assert spi_reset while in WAIT -> cyc/stb drop within the same cycle. A late ack causes no push. A subsequent start at 0x200 fetches 0x200 with count starting at 0.

Source files
------------

// File: rtl/qspi_read_prefetch_pkg.sv
// Shared types and constants for the QSPI read prefetcher.
// The NOR cycle codes normally come from the shared command defines; a
// fallback keeps this slice self-contained when those defines are absent.
`ifndef NOR_CYCLE_READ
`define NOR_CYCLE_READ 6'h01
`endif

package qspi_read_prefetch_pkg;

  // NOR command placed in the top six Wishbone address bits for a read.
  localparam logic [5:0] NOR_CMD_READ_DEFAULT = `NOR_CYCLE_READ;

  // Prefetch scheduler states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/qspi_read_prefetch_sync_fifo.sv
// Small synchronous FIFO holding prefetched NOR words. The head entry is
// presented directly from registered storage; pops on empty are ignored.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_n;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == {CW{1'b0}});
  assign full     = (count == DEPTH_C);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Next occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_n = count;
    case ({do_push, do_pop})
      2'b10:   count_n = count + CNT_ONE;
      2'b01:   count_n = count - CNT_ONE;
      default: count_n = count;
    endcase
  end

  // Storage write on push; cleared on reset so the head reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_n;
    end
  end

endmodule

// File: rtl/qspi_read_prefetch.sv
// Read prefetcher between the QSPI command FSM and the NOR Wishbone slave.
// After a read address phase it streams sequential NOR reads, one at a
// time, into a small FIFO so the host is served without NOR latency.
module qspi_read_prefetch
  import qspi_read_prefetch_pkg::*;
#(
  parameter int         ADDRBITS     = 26,
  parameter int         DATABITS     = 16,
  parameter int         DEPTH        = 4,
  parameter logic [5:0] NOR_CMD_READ = NOR_CMD_READ_DEFAULT
) (
  input  logic                clk_i,
  input  logic                spi_reset,
  input  logic                start_i,
  input  logic [ADDRBITS-1:0] start_addr_i,
  input  logic                pop_i,
  output logic [DATABITS-1:0] rd_data_o,
  output logic                rd_valid_o,
  output logic                busy_o,
  output logic                underrun_o,
  output logic                err_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [31:0]         wb_adr_o,
  input  logic [DATABITS-1:0] wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_stall_i,
  input  logic                wb_err_i
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]       DEPTH_C  = CW'(DEPTH);
  localparam logic [ADDRBITS-1:0] ADDR_ONE = ADDRBITS'(1'b1);

  state_t              state, state_n;
  logic                cyc, cyc_n;
  logic                stb, stb_n;
  logic [31:0]         adr, adr_n;
  logic [ADDRBITS-1:0] fetch_addr, fetch_addr_n;
  logic                err, err_n;
  logic                busy;
  logic                underrun;
  logic                push;
  logic                space;
  logic [CW-1:0]       count;
  logic                empty;
  logic                full;

  // Only one access is ever outstanding, and none is in flight whenever a
  // new request is being considered, so free space is simply count < DEPTH.
  assign space = (count < DEPTH_C);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATABITS)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (spi_reset),
    .push      (push),
    .push_data (wb_dat_i),
    .pop       (pop_i),
    .pop_data  (rd_data_o),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  // Next-state, Wishbone request and fetch address decisions.
  always_comb begin
    state_n      = state;
    cyc_n        = cyc;
    stb_n        = stb;
    adr_n        = adr;
    fetch_addr_n = fetch_addr;
    err_n        = err;
    push         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          fetch_addr_n = start_addr_i;
          state_n      = ST_ISSUE;
          if (space) begin
            cyc_n = 1'b1;
            stb_n = 1'b1;
            adr_n = {NOR_CMD_READ, start_addr_i};
          end else begin
            cyc_n = 1'b0;
            stb_n = 1'b0;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (stb) begin
          if (!wb_stall_i) begin
            stb_n   = 1'b0;
            state_n = ST_WAIT;
          end else begin
            stb_n = 1'b1;
          end
        end else if (space) begin
          cyc_n = 1'b1;
          stb_n = 1'b1;
          adr_n = {NOR_CMD_READ, fetch_addr};
        end else begin
          cyc_n = 1'b0;
        end
      end
      ST_WAIT: begin
        if (wb_err_i) begin
          cyc_n   = 1'b0;
          err_n   = 1'b1;
          state_n = ST_HALT;
        end else if (wb_ack_i) begin
          push         = !full;
          cyc_n        = 1'b0;
          fetch_addr_n = fetch_addr + ADDR_ONE;
          state_n      = ST_ISSUE;
        end else begin
          state_n = ST_WAIT;
        end
      end
      ST_HALT: begin
        cyc_n = 1'b0;
        stb_n = 1'b0;
      end
      default: begin
        state_n = ST_IDLE;
        cyc_n   = 1'b0;
        stb_n   = 1'b0;
      end
    endcase
  end

  // Control registers; reset aborts any Wishbone cycle immediately.
  always_ff @(posedge clk_i or posedge spi_reset) begin
    if (spi_reset) begin
      state      <= ST_IDLE;
      cyc        <= 1'b0;
      stb        <= 1'b0;
      adr        <= 32'h0000_0000;
      fetch_addr <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cyc        <= cyc_n;
      stb        <= stb_n;
      adr        <= adr_n;
      fetch_addr <= fetch_addr_n;
      err        <= err_n;
      busy       <= (state_n != ST_IDLE);
    end
  end

  // Sticky underrun flag: the host consumed a word that was not there.
  always_ff @(posedge clk_i or posedge spi_reset) begin
    if (spi_reset) begin
      underrun <= 1'b0;
    end else if (pop_i && empty) begin
      underrun <= 1'b1;
    end
  end

  assign rd_valid_o = !empty;
  assign busy_o     = busy;
  assign underrun_o = underrun;
  assign err_o      = err;
  assign wb_cyc_o   = cyc;
  assign wb_stb_o   = stb;
  assign wb_we_o    = 1'b0;
  assign wb_adr_o   = adr;

endmodule

// File: tb/tb_qspi_read_prefetch.sv
// Directed bench for qspi_read_prefetch with a Wishbone slave model and a
// scoreboard of expected read addresses and host-visible data words.
module tb_qspi_read_prefetch;
  import qspi_read_prefetch_pkg::*;

  localparam int ADDRBITS = 26;
  localparam int DATABITS = 16;
  localparam int DEPTH    = 4;
  localparam logic [5:0] CMD = NOR_CMD_READ_DEFAULT;

  logic                clk = 1'b0;
  logic                spi_reset;
  logic                start;
  logic [ADDRBITS-1:0] start_addr;
  logic                pop;
  logic [DATABITS-1:0] rd_data;
  logic                rd_valid, busy, underrun, err;
  logic                wb_cyc, wb_stb, wb_we;
  logic [31:0]         wb_adr;
  logic [DATABITS-1:0] wb_dat = 16'h0000;
  logic                wb_ack = 1'b0;
  logic                wb_stall = 1'b0;
  logic                wb_err = 1'b0;

  qspi_read_prefetch #(
    .ADDRBITS(ADDRBITS), .DATABITS(DATABITS), .DEPTH(DEPTH), .NOR_CMD_READ(CMD)
  ) dut (
    .clk_i(clk), .spi_reset(spi_reset), .start_i(start), .start_addr_i(start_addr),
    .pop_i(pop), .rd_data_o(rd_data), .rd_valid_o(rd_valid), .busy_o(busy),
    .underrun_o(underrun), .err_o(err), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
    .wb_we_o(wb_we), .wb_adr_o(wb_adr), .wb_dat_i(wb_dat), .wb_ack_i(wb_ack),
    .wb_stall_i(wb_stall), .wb_err_i(wb_err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  logic [ADDRBITS-1:0] exp_addr [$];
  logic [DATABITS-1:0] exp_data [$];

  int lat          = 3;
  int stall_cycles = 0;
  int err_at       = 0;
  int stall_cnt    = 0;
  int cd           = 0;
  int req_idx      = 0;
  logic stall_prev = 1'b0;
  logic [DATABITS-1:0] cur_word = 16'h0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wishbone slave model: stalls, delayed ack/err, address scoreboard.
  always @(negedge clk) begin
    logic [ADDRBITS-1:0] e;
    wb_ack = 1'b0;
    wb_err = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        wb_dat = cur_word;
        wb_ack = 1'b1;
        if (req_idx == err_at) wb_err = 1'b1;
        else exp_data.push_back(cur_word);
      end
    end
    if (stall_prev) check("stb_held_in_stall", {31'd0, wb_stb}, 32'd1);
    if (wb_cyc && wb_stb) begin
      if (stall_cnt < stall_cycles) begin
        wb_stall = 1'b1;
        stall_cnt++;
      end else begin
        wb_stall  = 1'b0;
        stall_cnt = 0;
        req_idx++;
        if (exp_addr.size() == 0) begin
          check("extra_read", 32'(exp_addr.size()), 32'd1);
        end else begin
          e = exp_addr.pop_front();
          check("rd_addr", wb_adr, {CMD, e});
          check("we_low", {31'd0, wb_we}, 32'd0);
          cur_word = e[15:0];
          cd = lat;
        end
      end
    end else begin
      wb_stall  = 1'b0;
      stall_cnt = 0;
    end
    stall_prev = wb_stall;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    spi_reset = 1'b1;
    tick(2);
    spi_reset = 1'b0;
    tick(1);
    exp_addr.delete();
    exp_data.delete();
    req_idx      = 0;
    err_at       = 0;
    stall_cycles = 0;
  endtask

  task automatic do_start(input logic [ADDRBITS-1:0] a);
    start_addr = a;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [DATABITS-1:0] e;
    check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    if (exp_data.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(exp_data.size()), 32'd1);
    end else begin
      e = exp_data.pop_front();
      check(tag, {16'd0, rd_data}, {16'd0, e});
    end
    pop = 1'b1;
    tick(1);
    pop = 1'b0;
  endtask

  initial begin
    spi_reset = 1'b1; start = 1'b0; pop = 1'b0; start_addr = '0;
    tick(3);
    check("rst_cyc", {31'd0, wb_cyc}, 32'd0);
    check("rst_stb", {31'd0, wb_stb}, 32'd0);
    check("rst_adr", wb_adr, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_data", {16'd0, rd_data}, 32'd0);
    check("rst_flags", {30'd0, underrun, err}, 32'd0);
    spi_reset = 1'b0;
    tick(1);

    // Prefill: four reads fill the FIFO, then the bus goes quiet.
    lat = 3;
    for (int i = 0; i < 4; i++) exp_addr.push_back(26'h100 + 26'(i));
    do_start(26'h100);
    check("pf_cyc", {31'd0, wb_cyc}, 32'd1);
    check("pf_stb", {31'd0, wb_stb}, 32'd1);
    check("pf_busy", {31'd0, busy}, 32'd1);
    tick(60);
    check("pf_reads", 32'(exp_addr.size()), 32'd0);
    check("pf_idle_cyc", {31'd0, wb_cyc}, 32'd0);
    check("pf_valid", {31'd0, rd_valid}, 32'd1);
    check("pf_head", {16'd0, rd_data}, 32'h0000_0100);

    // Streaming: each pop triggers one refill read.
    for (int i = 0; i < 12; i++) exp_addr.push_back(26'h104 + 26'(i));
    for (int i = 0; i < 12; i++) begin
      pop_check("stream");
      tick(9);
    end
    tick(10);
    check("stream_reads", 32'(exp_addr.size()), 32'd0);
    check("stream_no_underrun", {31'd0, underrun}, 32'd0);
    do_reset();

    // Address wrap with two stall cycles per request.
    stall_cycles = 2; lat = 1;
    exp_addr.push_back(26'h3FFFFFE); exp_addr.push_back(26'h3FFFFFF);
    exp_addr.push_back(26'h0000000); exp_addr.push_back(26'h0000001);
    do_start(26'h3FFFFFE);
    tick(40);
    check("wrap_reads", 32'(exp_addr.size()), 32'd0);
    exp_addr.push_back(26'h0000002);
    pop_check("wrap_data");
    tick(12);
    check("wrap_refill", 32'(exp_addr.size()), 32'd0);
    do_reset();

    // Underrun: pop immediately after start, before any data.
    lat = 8;
    for (int i = 0; i < 4; i++) exp_addr.push_back(26'h300 + 26'(i));
    do_start(26'h300);
    check("ur_empty", {31'd0, rd_valid}, 32'd0);
    pop = 1'b1;
    tick(1);
    pop = 1'b0;
    check("ur_set", {31'd0, underrun}, 32'd1);
    tick(70);
    check("ur_sticky", {31'd0, underrun}, 32'd1);
    check("ur_reads", 32'(exp_addr.size()), 32'd0);
    exp_addr.push_back(26'h304);
    pop_check("ur_first");
    tick(15);
    do_reset();
    check("ur_cleared", {31'd0, underrun}, 32'd0);

    // Error on the second read halts fetching; fetched word still drains.
    lat = 3; err_at = 2;
    exp_addr.push_back(26'h400); exp_addr.push_back(26'h401);
    do_start(26'h400);
    tick(40);
    check("err_set", {31'd0, err}, 32'd1);
    check("err_busy", {31'd0, busy}, 32'd1);
    check("err_cyc", {31'd0, wb_cyc}, 32'd0);
    check("err_reads", 32'(exp_addr.size()), 32'd0);
    pop_check("err_drain");
    check("err_empty", {31'd0, rd_valid}, 32'd0);
    tick(10);
    check("err_quiet", {31'd0, wb_cyc}, 32'd0);
    do_reset();
    check("err_cleared", {31'd0, err}, 32'd0);

    // Abort: reset during WAIT drops the bus at once; late ack is ignored.
    lat = 6;
    exp_addr.push_back(26'h500);
    do_start(26'h500);
    tick(1);
    check("ab_wait_cyc", {31'd0, wb_cyc}, 32'd1);
    check("ab_wait_stb", {31'd0, wb_stb}, 32'd0);
    #2 spi_reset = 1'b1;
    #1;
    check("ab_cyc_drop", {31'd0, wb_cyc}, 32'd0);
    check("ab_busy_drop", {31'd0, busy}, 32'd0);
    tick(2);
    spi_reset = 1'b0;
    tick(10);
    check("ab_no_push", {31'd0, rd_valid}, 32'd0);
    exp_data.delete();
    exp_addr.delete();
    req_idx = 0;
    lat = 2;
    for (int i = 0; i < 4; i++) exp_addr.push_back(26'h200 + 26'(i));
    do_start(26'h200);
    tick(40);
    check("ab_reads", 32'(exp_addr.size()), 32'd0);
    check("ab_full_quiet", {31'd0, wb_cyc}, 32'd0);
    exp_addr.push_back(26'h204);
    pop_check("ab_restart");
    tick(10);
    check("ab_refill", 32'(exp_addr.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
